// File: rtl/lfsr_bank.sv
// lfsr_bank: bank of NCH independent XNOR Fibonacci LFSRs sharing one step enable.
//
// Each channel i shifts left and inserts fb_i = ~^(state_i & TAPS_i) at bit 0. The only
// fixed point of an XNOR LFSR is all-ones, reachable only with an even tap count. When a
// channel sits there and a step is requested, it is forced to zero and its sticky
// lock_flag bit is set. Only a seed load to that channel clears the flag.
//
// A one-entry output register lets the bus side sample any channel with valid/ready
// handshaking, without ever stalling generation.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   advance every channel one step this cycle
//   load       in   seed strobe
//   load_ch    in   channel to seed (values >= NCH are ignored)
//   load_data  in   seed value
//   rd_valid   in   read request
//   rd_ch      in   channel to sample (values >= NCH read as zero)
//   rd_ready   out  read accepted when high together with rd_valid
//   out_valid  out  sampled value available
//   out_data   out  sampled channel state (pre-edge value of the accepted read)
//   out_ready  in   consumer accepts out_data
//   lock_flag  out  sticky per-channel lock-up indicator
module lfsr_bank #(
  parameter int unsigned          WIDTH = 32,
  parameter int unsigned          NCH   = 4,
  parameter int unsigned          CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter logic [NCH*WIDTH-1:0] TAPS  = {32'h4040_1080, 32'h0400_4050,
                                           32'h0011_2014, 32'h0001_040C}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CHW-1:0]   load_ch,
  input  logic [WIDTH-1:0] load_data,
  input  logic             rd_valid,
  input  logic [CHW-1:0]   rd_ch,
  output logic             rd_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [NCH-1:0]   lock_flag
);

  // Elaboration-time parameter sanity.
  if (WIDTH < 4) begin : g_bad_width
    $error("lfsr_bank: WIDTH must be at least 4");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("lfsr_bank: NCH must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] state_q [NCH];
  logic [WIDTH-1:0] state_d [NCH];
  logic [NCH-1:0]   lock_q;
  logic [NCH-1:0]   lock_d;

  logic [NCH-1:0]   fb;
  logic [NCH-1:0]   lockup;
  logic [NCH-1:0]   load_hit;

  always_comb begin : feedback
    fb       = '0;
    lockup   = '0;
    load_hit = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fb[i]       = ~^(state_q[i] & TAPS[i*WIDTH +: WIDTH]);
      lockup[i]   = (&state_q[i]) & fb[i];
      // An out-of-range load_ch matches no channel, so such loads drop out naturally.
      load_hit[i] = load && (load_ch == CHW'(i));
    end
  end

  always_comb begin : next_state
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      lock_d[i]  = lock_q[i];
      if (load_hit[i]) begin
        state_d[i] = load_data;
        lock_d[i]  = 1'b0;
      end else if (en && lockup[i]) begin
        // Escape the all-ones fixed point; zero is legal since its feedback is 1.
        state_d[i] = '0;
        lock_d[i]  = 1'b1;
      end else if (en) begin
        state_d[i] = {state_q[i][WIDTH-2:0], fb[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= '0;
      end
      lock_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
      end
      lock_q <= lock_d;
    end
  end

  assign lock_flag = lock_q;

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rd_sel;
  logic             rd_fire;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;

  // Sample the pre-edge state; unmatched selects (rd_ch >= NCH) read as zero.
  always_comb begin : read_mux
    rd_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i)) begin
        rd_sel = state_q[i];
      end
    end
  end

  assign rd_ready = !out_valid_q || out_ready;
  assign rd_fire  = rd_valid && rd_ready;

  always_comb begin : out_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (rd_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : out_reg
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed self-checking bench for lfsr_bank with the default 4 x 32-bit configuration.
// Default taps: ch0 0x0001040C (4 taps), ch1 0x00112014 (5 taps),
//               ch2 0x04004050 (4 taps), ch3 0x40401080 (4 taps).
module tb_lfsr_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [1:0]  load_ch;
  logic [31:0] load_data;
  logic        rd_valid;
  logic [1:0]  rd_ch;
  logic        rd_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  lock_flag;

  int checks;
  int errors;

  lfsr_bank dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_ch   (load_ch),
    .load_data (load_data),
    .rd_valid  (rd_valid),
    .rd_ch     (rd_ch),
    .rd_ready  (rd_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .lock_flag (lock_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
  endtask

  task automatic seed(input logic [1:0] ch, input logic [31:0] val);
    load      = 1'b1;
    load_ch   = ch;
    load_data = val;
    tick();
    load      = 1'b0;
  endtask

  // Read one channel with out_ready high; leaves the output register empty afterwards.
  task automatic do_read(input logic [1:0] ch, output logic [31:0] data);
    out_ready = 1'b1;
    rd_valid  = 1'b1;
    rd_ch     = ch;
    tick();
    data      = out_data;
    rd_valid  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || lock_flag !== 4'h0 || rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b od=%h lf=%b rr=%b want 0/0/0/1",
               out_valid, out_data, lock_flag, rd_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    do_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_state_ch0 got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_step_seq();
    logic [31:0] exp [4];
    logic [31:0] d;
    exp[0] = 32'h0000_0001;
    exp[1] = 32'h0000_0003;
    exp[2] = 32'h0000_0007;
    exp[3] = 32'h0000_000E;
    for (int i = 0; i < 4; i++) begin
      step(1);
      do_read(2'd0, d);
      checks++;
      if (d !== exp[i]) begin
        errors++;
        $display("FAIL step_ch0_%0d got %h want %h", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_lockup();
    logic [31:0] d;
    seed(2'd2, 32'hFFFF_FFFF);
    step(1);
    checks++;
    if (lock_flag !== 4'b0100) begin
      errors++;
      $display("FAIL lock_rise got %b want %b", lock_flag, 4'b0100);
    end
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL lock_recover_state got %h want %h", d, 32'h0);
    end
    step(1);
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0001 || lock_flag[2] !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_step got %h/%b want %h/1", d, lock_flag[2], 32'h1);
    end
    seed(2'd2, 32'h1234_5678);
    checks++;
    if (lock_flag[2] !== 1'b0) begin
      errors++;
      $display("FAIL lock_clear got %b want 0", lock_flag[2]);
    end
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL lock_reload got %h want %h", d, 32'h1234_5678);
    end
  endtask

  task automatic test_odd_taps();
    logic [31:0] d;
    seed(2'd1, 32'hFFFF_FFFF);
    step(1);
    do_read(2'd1, d);
    checks++;
    if (d !== 32'hFFFF_FFFE || lock_flag !== 4'b0000) begin
      errors++;
      $display("FAIL odd_taps got %h/%b want %h/0000", d, lock_flag, 32'hFFFF_FFFE);
    end
  endtask

  task automatic test_backpressure();
    seed(2'd0, 32'hCAFE_F00D);
    out_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_ch     = 2'd0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFE_F00D || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got ov=%b od=%h rr=%b want 1/%h/0",
               out_valid, out_data, rd_ready, 32'hCAFE_F00D);
    end
    rd_ch = 2'd1;
    seed(2'd0, 32'h0BAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_data !== 32'hCAFE_F00D || rd_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got od=%h rr=%b ov=%b want %h/0/1",
                 i, out_data, rd_ready, out_valid, 32'hCAFE_F00D);
      end
    end
    rd_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb got %b want 1", rd_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    seed(2'd0, 32'h0000_0001);
    seed(2'd1, 32'h0000_0001);
    seed(2'd2, 32'h0000_0001);
    seed(2'd3, 32'h0000_0100);
    // Load ch3, read ch3 and step all in one cycle.
    load      = 1'b1;
    load_ch   = 2'd3;
    load_data = 32'hA5A5_A5A5;
    rd_valid  = 1'b1;
    rd_ch     = 2'd3;
    out_ready = 1'b1;
    en        = 1'b1;
    tick();
    load     = 1'b0;
    en       = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0100) begin
      errors++;
      $display("FAIL same_cycle_old got %b/%h want 1/%h", out_valid, out_data, 32'h100);
    end
    // Second read issued straight after, sustaining one read per cycle.
    rd_ch = 2'd3;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL same_cycle_new got %b/%h want 1/%h", out_valid, out_data, 32'hA5A5_A5A5);
    end
    rd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      do_read(2'(i), d);
      checks++;
      if (d !== 32'h0000_0003) begin
        errors++;
        $display("FAIL unaddressed_step_ch%0d got %h want %h", i, d, 32'h3);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    seed(2'd2, 32'hFFFF_FFFF);
    step(2);
    out_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_ch     = 2'd3;
    tick();
    rd_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data === 32'h0 || lock_flag !== 4'b0100) begin
      errors++;
      $display("FAIL pre_reset got ov=%b od=%h lf=%b want 1/nonzero/0100",
               out_valid, out_data, lock_flag);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || lock_flag !== 4'h0 || rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got ov=%b od=%h lf=%b rr=%b want 0/0/0/1",
               out_valid, out_data, lock_flag, rd_ready);
    end
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), d);
      checks++;
      if (d !== 32'h0000_0001) begin
        errors++;
        $display("FAIL post_reset_ch%0d got %h want %h", i, d, 32'h1);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    load_ch   = 2'd0;
    load_data = 32'h0;
    rd_valid  = 1'b0;
    rd_ch     = 2'd0;
    out_ready = 1'b1;
    test_reset();
    test_step_seq();
    test_lockup();
    test_odd_taps();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Parametrised multi-channel XNOR Fibonacci LFSR bank. It is the successor to the fixed 32-bit single-tap-set generators.

- Provides NCH independent pseudo-random channels, each with its own tap mask.
- Supports per-channel seed load, a shared step enable, and lock-up detection with automatic recovery.
- Exposes a valid/ready read port so the bus interface can sample any channel without stalling generation.

## Interface

Parameters:
- WIDTH, 32, register width per channel (>= 4).
- NCH, 4, channel count (>= 1).
- CHW, $clog2(NCH) (min 1), channel-select width.
- TAPS, {32'h4040_1080, 32'h0400_4050, 32'h0011_2014, 32'h0001_040C}, packed NCH*WIDTH tap masks; channel i uses TAPS[i*WIDTH +: WIDTH].

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance every channel one step this cycle.
- load  in  1  seed strobe.
- load_ch  in  CHW  channel to seed.
- load_data  in  WIDTH  seed value.
- rd_valid  in  1  read request.
- rd_ch  in  CHW  channel to sample.
- rd_ready  out  1  read request accepted when high with rd_valid.
- out_valid  out  1  sampled value available.
- out_data  out  WIDTH  sampled channel state.
- out_ready  in  1  consumer accepts out_data.
- lock_flag  out  NCH  sticky per-channel lock-up indicator.

## Operation

- Per-channel feedback: fb_i = ~^(state_i & TAPS_i).
- Step: state_i <= {state_i[WIDTH-2:0], fb_i}.
- Per-cycle update priority for channel i:
  - load && load_ch==i: state_i <= load_data and lock_flag[i] <= 0.
  - else en && lockup_i: state_i <= 0 and lock_flag[i] <= 1 (recovery).
  - else en: step.
  - else: hold.
- lockup_i = (state_i == all-ones) && fb_i. This is the only fixed point of an XNOR LFSR, and it occurs only when the channel has an even tap count.
- Unaddressed channels keep stepping during a load to another channel.
- load_ch >= NCH: load is ignored.
- rd_ch >= NCH: the read is accepted and returns 0.
- Read port is a single output register:
  - rd_ready = !out_valid || out_ready.
  - On rd_valid && rd_ready, out_data <= the current (pre-edge) state of rd_ch, and out_valid <= 1.
  - If out_valid && out_ready && !(rd_valid && rd_ready), then out_valid <= 0.
  - out_data holds stable while out_valid && !out_ready.
- lock_flag[i] stays set until a load to channel i. A recovery step does not clear it.

## Timing

- Reset (asynchronous, takes effect immediately):
  - all state_i = 0
  - out_valid = 0
  - out_data = 0
  - lock_flag = 0
  - rd_ready = 1 (combinational)
- State update: one cycle. A loaded value is visible to a read issued the following cycle.
- Read latency: request accepted at edge N gives out_valid=1 after edge N. Back-to-back reads sustain 1 per cycle while out_ready=1.
- A simultaneous read and load of the same channel returns the pre-load value.
- A simultaneous read and step returns the pre-step value.
- Reset asserted mid-transfer drops the pending out_valid with no completion. After release, the first step from 0 gives state 0x00000001 on every channel.
- All-zero state is legal and non-locking, because fb = 1.

## Test plan

- Reset, then en=1 for 4 cycles, reading ch0 after each step -> 0x00000001, 0x00000003, 0x00000007, 0x0000000E.
- Load ch2 = 0xFFFFFFFF (4 taps), en=1 -> lock_flag[2] rises after 1 step and ch2 reads 0x00000000. The next step gives 0x00000001. lock_flag[2] stays 1 until a load of 0x12345678 to ch2 clears it.
- Load ch1 = 0xFFFFFFFF (5 taps), en=1 one cycle -> ch1 = 0xFFFFFFFE and lock_flag[1] = 0.
- Hold out_ready=0 with rd_valid=1 -> first read accepted; rd_ready=0 afterwards; out_data stable for 5 cycles. Raising out_ready completes the transfer and rd_ready returns to 1 the same cycle.
- In the same cycle, load ch3 = 0xA5A5A5A5, read ch3, en=1 -> read returns the old ch3 value. The next read (en=0) returns 0xA5A5A5A5. Channels 0-2 each advanced one step.
- Assert rst while out_valid=1 and the states are nonzero -> out_valid, out_data, lock_flag and all states are 0 immediately. After release, en=1 gives all channels 0x00000001.
